// File: rtl/data_bus_arbiter_pkg.sv
// Shared constants for the data-side bus: address map, requester indices, arbiter states.
// The tie-break policy itself is selected in bus_arb_pick by ARB_ROUND_ROBIN_EN.
package data_bus_arbiter_pkg;
  localparam logic [31:0] DMEM_BASE  = 32'h0000_0000;
  localparam logic [31:0] DMEM_LIMIT = 32'h0000_3FFF;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_SEC = 1'b1;

  localparam int MAX_BURST_DEF = 4;
  localparam int BURST_W       = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  byteen;
  } bus_req_t;
endpackage

// File: rtl/data_bus_arbiter_pick.sv
// Combinational winner select for the two bus masters.
// ARB_ROUND_ROBIN_EN: ties go to the non-last owner; otherwise ties go to the CPU.
module bus_arb_pick
  import data_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic [1:0]         req_i,
  input  logic               last_owner_i,
  input  logic [BURST_W-1:0] burst_cnt_i,
  output logic [1:0]         gnt_o
);
  logic tie_win;

  always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
    tie_win = ~last_owner_i;
`else
    tie_win = REQ_CPU;
`endif
    // Burst limit overrides the tie rule: hand the bus to the waiting side.
    if (burst_cnt_i == BURST_W'(MAX_BURST - 1)) tie_win = ~last_owner_i;

    gnt_o = 2'b00;
    case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      2'b11:   gnt_o = tie_win ? 2'b10 : 2'b01;
      default: gnt_o = 2'b00;
    endcase
  end
endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master arbiter in front of the data-memory port: grant, register onto bus, return data.
// Tie policy chosen by ARB_ROUND_ROBIN_EN (default: fixed CPU priority with burst limit).
module data_bus_arbiter
  import data_bus_arbiter_pkg::*;
#(
  parameter int MAX_BURST = MAX_BURST_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  input  logic [3:0]  byteen0,
  input  logic [3:0]  byteen1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rvalid0,
  output logic        rvalid1,
  output logic [31:0] rdata,
  output logic [31:0] m_data_addr,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  input  logic [31:0] m_data_rdata
);
  arb_state_e          state_q;
  logic                last_owner_q;
  logic [BURST_W-1:0]  burst_q, burst_d;
  bus_req_t            bus_q;
  bus_req_t [1:0]      cand;
  logic [1:0]          rvalid_q;
  logic [31:0]         rdata_q;
  logic [1:0]          pick, gnt;
  logic                win, other_req;

  assign cand[0] = '{addr: addr0, wdata: wdata0, byteen: byteen0};
  assign cand[1] = '{addr: addr1, wdata: wdata1, byteen: byteen1};

  bus_arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .req_i        ({req1, req0}),
    .last_owner_i (last_owner_q),
    .burst_cnt_i  (burst_q),
    .gnt_o        (pick)
  );

  assign gnt       = reset ? 2'b00 : pick;
  assign win       = gnt[1];
  assign other_req = win ? req0 : req1;

  always_comb begin
    burst_d = '0;
    if (win == last_owner_q && other_req) burst_d = burst_q + BURST_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_owner_q <= REQ_SEC;
      burst_q      <= '0;
      bus_q        <= '0;
      rvalid_q     <= '0;
      rdata_q      <= '0;
    end else begin
      // Completion follows the bus phase; a reset during it drops the pulse.
      rvalid_q <= {state_q == ST_OWN1, state_q == ST_OWN0};
      if (state_q != ST_IDLE) rdata_q <= m_data_rdata;
      if (|gnt) begin
        state_q      <= win ? ST_OWN1 : ST_OWN0;
        bus_q        <= cand[win];
        last_owner_q <= win;
        burst_q      <= burst_d;
      end else begin
        state_q      <= ST_IDLE;
        bus_q.byteen <= '0;
        burst_q      <= '0;
      end
    end
  end

  assign gnt0          = gnt[0];
  assign gnt1          = gnt[1];
  assign rvalid0       = rvalid_q[0];
  assign rvalid1       = rvalid_q[1];
  assign rdata         = rdata_q;
  assign m_data_addr   = bus_q.addr;
  assign m_data_wdata  = bus_q.wdata;
  assign m_data_byteen = bus_q.byteen;
endmodule
